// File: rtl/ysyx_24090018_arb_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encoding,
// master IDs and default bus widths.
package ysyx_24090018_arb_pkg;

   localparam int unsigned ARB_ADDR_W      = 32;
   localparam int unsigned ARB_DATA_W      = 32;
   localparam int unsigned ARB_TIMEOUT_CYC = 255;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_e;

   localparam logic MST_IFU = 1'b0;
   localparam logic MST_LSU = 1'b1;

   function automatic logic [1:0] id_to_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ysyx_24090018_rr_pick.sv
// Two-way round-robin winner select: on a tie the master that did not
// own the previous transaction wins.
module ysyx_24090018_rr_pick
   import ysyx_24090018_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic [1:0] grant,
   output logic       winner
);

   always_comb begin
      winner = MST_IFU;
      grant  = 2'b00;
      case (req)
         2'b01:   winner = MST_IFU;
         2'b10:   winner = MST_LSU;
         2'b11:   winner = ~last_owner;
         default: winner = MST_IFU;
      endcase
      if (|req) begin
         grant = id_to_onehot(winner);
      end
   end

endmodule

// File: rtl/ysyx_24090018_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter, one transaction in flight.
// Optional WAIT-state response timeout is enabled with `define ARB_TIMEOUT_EN.
module ysyx_24090018_mem_arbiter
   import ysyx_24090018_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = ARB_ADDR_W,
   parameter int unsigned DATA_W      = ARB_DATA_W,
   parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
   input  logic                clk,
   input  logic                rst_n,

   input  logic                m0_req_valid,
   output logic                m0_req_ready,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic                m0_wen,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wmask,
   output logic                m0_resp_valid,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic                m0_resp_err,

   input  logic                m1_req_valid,
   output logic                m1_req_ready,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic                m1_wen,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wmask,
   output logic                m1_resp_valid,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                m1_resp_err,

   output logic                s_req_valid,
   output logic [ADDR_W-1:0]   s_addr,
   output logic                s_wen,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wmask,
   input  logic                s_req_ready,
   input  logic                s_resp_valid,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic                s_resp_err
);

   localparam int unsigned MASK_W = DATA_W / 8;

   if (TIMEOUT_CYC == 0) begin : g_cfg_chk
      $error("TIMEOUT_CYC must be at least 1");
   end

   arb_state_e          state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_owner_q, last_owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MASK_W-1:0]   wmask_q, wmask_d;

   logic [1:0]          req_vec;
   logic [1:0]          grant;
   logic                winner;
   logic                resp_fire;
   logic [DATA_W-1:0]   resp_data;
   logic                resp_err;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                timeout_hit;

   // Last WAIT cycle before giving up is the TIMEOUT_CYC-th one (count starts at 0).
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

   // Requests are masked during reset so no accept pulse can leak out.
   assign req_vec = {m1_req_valid, m0_req_valid} & {2{rst_n}};

   ysyx_24090018_rr_pick u_rr_pick (
      .req        (req_vec),
      .last_owner (last_owner_q),
      .grant      (grant),
      .winner     (winner)
   );

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_owner_d  = last_owner_q;
      addr_d        = addr_q;
      wen_d         = wen_q;
      wdata_d       = wdata_q;
      wmask_d       = wmask_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d         = cnt_q;
`endif
      resp_fire     = 1'b0;
      resp_data     = '0;
      resp_err      = 1'b0;

      m0_req_ready  = 1'b0;
      m1_req_ready  = 1'b0;
      m0_resp_valid = 1'b0;
      m0_rdata      = '0;
      m0_resp_err   = 1'b0;
      m1_resp_valid = 1'b0;
      m1_rdata      = '0;
      m1_resp_err   = 1'b0;
      s_req_valid   = 1'b0;
      s_addr        = '0;
      s_wen         = 1'b0;
      s_wdata       = '0;
      s_wmask       = '0;

      case (state_q)
         ST_IDLE: begin
            if (|req_vec) begin
               m0_req_ready = grant[0];
               m1_req_ready = grant[1];
               owner_d      = winner;
               addr_d       = winner ? m1_addr  : m0_addr;
               wen_d        = winner ? m1_wen   : m0_wen;
               wdata_d      = winner ? m1_wdata : m0_wdata;
               wmask_d      = winner ? m1_wmask : m0_wmask;
               state_d      = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            s_req_valid = 1'b1;
            s_addr      = addr_q;
            s_wen       = wen_q;
            s_wdata     = wdata_q;
            s_wmask     = wmask_q;
            if (s_req_ready) begin
               state_d = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end

         ST_WAIT: begin
            resp_fire = s_resp_valid;
            resp_data = s_rdata;
            resp_err  = s_resp_err;
`ifdef ARB_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
            // A real response in the timeout cycle wins over the synthetic error.
            if (!s_resp_valid && timeout_hit) begin
               resp_fire = 1'b1;
               resp_data = '0;
               resp_err  = 1'b1;
            end
`endif
            if (resp_fire) begin
               if (owner_q == MST_IFU) begin
                  m0_resp_valid = 1'b1;
                  m0_rdata      = resp_data;
                  m0_resp_err   = resp_err;
               end else begin
                  m1_resp_valid = 1'b1;
                  m1_rdata      = resp_data;
                  m1_resp_err   = resp_err;
               end
               last_owner_d = owner_q;
               state_d      = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= MST_IFU;
         last_owner_q <= MST_LSU;
         addr_q       <= '0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         wmask_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         addr_q       <= addr_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

endmodule

// File: doc/ysyx_24090018_mem_arbiter.md
YSYX_24090018_MEM_ARBITER -- requirements
Module: ysyx_24090018_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width.
REQ-002 Parameter DATA_W, default 32: data width; mask width is DATA_W/8.
REQ-003 Parameter TIMEOUT_CYC, default 255: WAIT-cycle limit, used only with the timeout feature.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 m{0,1}_req_valid  in  1  per-master request (m0 = IFU, m1 = LSU).
REQ-007 m{0,1}_req_ready  out  1  per-master accept pulse.
REQ-008 m{0,1}_addr / _wen / _wdata / _wmask  in  ADDR_W / 1 / DATA_W / DATA_W/8  request fields.
REQ-009 m{0,1}_resp_valid / _rdata / _resp_err  out  1 / DATA_W / 1  per-master response.
REQ-010 s_req_valid, s_addr, s_wen, s_wdata, s_wmask  out  1 / ADDR_W / 1 / DATA_W / DATA_W/8  downstream request.
REQ-011 s_req_ready  in  1  downstream accept.
REQ-012 s_resp_valid / s_rdata / s_resp_err  in  1 / DATA_W / 1  downstream response.

Function
REQ-013 The block SHALL implement the FSM IDLE -> ISSUE -> WAIT -> IDLE, with one transaction outstanding at most.
REQ-014 In IDLE with any mN_req_valid=1, the block SHALL assert mN_req_ready for the winner only (combinational, same cycle), latch the winner's fields and owner ID, and enter ISSUE.
REQ-015 On a tie, the winner SHALL be the master other than last_owner; last_owner resets to 1, so m0 wins the first tie.
REQ-016 In ISSUE, s_req_valid SHALL be 1 with the latched fields held stable until s_req_ready=1; the FSM then enters WAIT.
REQ-017 s_resp_valid in IDLE or ISSUE SHALL be ignored.
REQ-018 In WAIT, when s_resp_valid=1, the owner's resp_valid SHALL be 1 for exactly that cycle with rdata=s_rdata and resp_err=s_resp_err; last_owner SHALL be updated to the owner; the FSM SHALL return to IDLE.
REQ-019 Outputs of the non-owner, and mN_rdata whenever resp_valid=0, SHALL be 0.
REQ-020 s_* request outputs SHALL be 0 outside ISSUE.
REQ-021 Minimum transaction spacing SHALL be 3 cycles; no new acceptance occurs in the response cycle.
REQ-022 A master deasserting req_valid before acceptance SHALL NOT be granted.

Reset
REQ-023 rst_n=0 SHALL force IDLE and last_owner=1, clear the latched fields and timeout counter, and drive all outputs to 0 immediately.
REQ-024 A transaction in flight at reset SHALL be dropped with no response generated.

Configuration
REQ-025 With ARB_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each cycle in WAIT.
REQ-026 With ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYC without s_resp_valid SHALL produce an owner response with resp_err=1 and rdata=0, and the FSM SHALL return to IDLE.
REQ-027 With ARB_TIMEOUT_EN defined, if s_resp_valid arrives in the same cycle as the timeout, the real response SHALL take precedence.
REQ-028 Without ARB_TIMEOUT_EN, the counter logic SHALL be absent and WAIT SHALL persist indefinitely.

Structure
REQ-029 The shared package ysyx_24090018_arb_pkg SHALL hold the state encoding (IDLE=0, ISSUE=1, WAIT=2), master ID constants (IFU=0, LSU=1), and the default width constants.
REQ-030 Winner selection SHALL be in the sub-module ysyx_24090018_rr_pick: inputs req[1:0] and last_owner; outputs grant[1:0] and winner ID.

Verification
REQ-031 m0 alone reads addr 0x80000000; s_req_ready=1 in ISSUE; s_rdata=0x00000413 two cycles later -> m0_resp_valid 1 cycle with rdata 0x00000413; m1 outputs all 0.
REQ-032 m0 and m1 request simultaneously after reset -> m0 granted first, then m1 on the next IDLE; a repeated tie alternates m0, m1, m0.
REQ-033 s_req_ready held 0 for 5 cycles in ISSUE -> s_addr/s_wdata/s_wmask stable for all 5 cycles; m1 (wen=1, wdata=0xDEADBEEF, wmask=0xF) forwarded unchanged.
REQ-034 rst_n pulsed low during WAIT -> all outputs 0 in the same cycle; the late s_resp_valid is ignored; the next tie goes to m0.
REQ-035 With ARB_TIMEOUT_EN and TIMEOUT_CYC=4, no response arrives -> after 4 WAIT cycles the owner gets resp_err=1, rdata=0; a stray s_resp_valid in the following IDLE produces no output.
